// File: rtl/snow64_instr_encoder.sv
// Packs decoded Snow64 instruction fields into 32-bit words, flags illegal field combinations,
// and queues results in a small valid/ready output FIFO. Latency 1 cycle; in_ready = !full (registered).
module snow64_instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_group,
  input  logic               in_op_type,
  input  logic [3:0]         in_ra,
  input  logic [3:0]         in_rb,
  input  logic [3:0]         in_rc,
  input  logic [3:0]         in_oper,
  input  logic [63:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_err,
  output logic [1:0]         out_err_code,
  output logic [COUNT_W-1:0] enc_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);

  logic        w_bad_grp;
  logic        w_bad_oper;
  logic        w_imm_used;
  logic        w_fit12;
  logic        w_fit20;
  logic        w_bad_imm;
  logic [1:0]  w_code;
  logic [31:0] w_instr;

  logic [31:0]        r_mem_instr [FIFO_DEPTH];
  logic [1:0]         r_mem_code  [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_full;
  logic [COUNT_W-1:0] r_enc_count;

  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_count_nxt;

  // Oper legality and immediate usage, per group.
  always_comb begin
    w_bad_oper = 1'b0;
    w_imm_used = 1'b0;
    unique case (in_group[1:0])
      2'd0: begin
        w_bad_oper = (in_oper >= 4'd14);
        w_imm_used = (in_oper == 4'd12) || (in_oper == 4'd13);
      end
      2'd1: begin
        w_bad_oper = (in_oper >= 4'd3);
        w_imm_used = (in_oper <= 4'd1);
      end
      default: begin
        w_bad_oper = (in_oper >= 4'd9);
        w_imm_used = 1'b1;
      end
    endcase
  end

  assign w_bad_grp = in_group[2];
  assign w_fit12   = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign w_fit20   = (&in_imm[63:19]) | ~(|in_imm[63:19]);
  assign w_bad_imm = w_imm_used && ((in_group == 3'd1) ? !w_fit20 : !w_fit12);

  always_comb begin
    w_code = 2'd0;
    if (w_bad_grp)       w_code = 2'd1;
    else if (w_bad_oper) w_code = 2'd2;
    else if (w_bad_imm)  w_code = 2'd3;
  end

  // Illegal words fall back to the group-0 layout with a truncated immediate.
  always_comb begin
    w_instr = {in_group, in_op_type, in_ra, in_rb, in_rc, in_oper, in_imm[11:0]};
    if (w_code == 2'd0) begin
      if (in_group == 3'd1)
        w_instr = {in_group, 1'b0, in_ra, in_oper,
                   w_imm_used ? in_imm[19:0] : 20'h0};
      else
        w_instr = {in_group, (in_group == 3'd0) & in_op_type, in_ra, in_rb, in_rc,
                   in_oper, w_imm_used ? in_imm[11:0] : 12'h0};
    end
  end

  assign w_push = in_valid && !r_full;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_instr[i] <= 32'h0;
        r_mem_code[i]  <= 2'd0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_enc_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= w_instr;
        r_mem_code[r_wr_ptr]  <= w_code;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
        if (w_code == 2'd0)
          r_enc_count <= r_enc_count + COUNT_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
    end
  end

  assign in_ready     = !r_full;
  assign out_valid    = (r_count != '0);
  assign out_instr    = r_mem_instr[r_rd_ptr];
  assign out_err_code = r_mem_code[r_rd_ptr];
  assign out_err      = (r_mem_code[r_rd_ptr] != 2'd0);
  assign enc_count    = r_enc_count;

endmodule

// File: tb/tb_snow64_instr_encoder.sv
// Randomized bench for snow64_instr_encoder: a field-level reference model predicts every
// popped word, plus directed checks for reset, known encodings, backpressure and mid-run reset.
module tb_snow64_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_group;
  logic        in_op_type;
  logic [3:0]  in_ra, in_rb, in_rc, in_oper;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic [15:0] enc_count;

  snow64_instr_encoder #(.FIFO_DEPTH(2), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_group(in_group), .in_op_type(in_op_type), .in_ra(in_ra), .in_rb(in_rb),
    .in_rc(in_rc), .in_oper(in_oper), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .out_err_code(out_err_code), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  code;
  } exp_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint p2(input int n);
    return longint'(1) <<< n;
  endfunction

  // Reference: legality rules then field packing as a weighted sum.
  function automatic exp_t model(input int g, input int ot, input int ra, input int rb,
                                 input int rc, input int oper, input longint imm);
    exp_t   e;
    bit     used;
    int     w;
    int     maxop;
    longint lim;
    longint f;
    used  = (g == 0 && (oper == 12 || oper == 13)) || (g == 1 && oper <= 1) || g == 2 || g == 3;
    w     = (g == 1) ? 20 : 12;
    lim   = p2(w - 1);
    maxop = (g == 0) ? 13 : (g == 1) ? 2 : 8;
    e.code = 2'd0;
    if (g >= 4) e.code = 2'd1;
    else if (oper > maxop) e.code = 2'd2;
    else if (used && (imm < -lim || imm > lim - 1)) e.code = 2'd3;
    if (e.code != 2'd0)
      f = g * p2(29) + ot * p2(28) + ra * p2(24) + rb * p2(20) + rc * p2(16)
          + oper * p2(12) + (imm & (p2(12) - 1));
    else if (g == 1)
      f = g * p2(29) + ra * p2(24) + oper * p2(20) + (used ? (imm & (p2(20) - 1)) : 0);
    else
      f = g * p2(29) + ((g == 0) ? ot : 0) * p2(28) + ra * p2(24) + rb * p2(20)
          + rc * p2(16) + oper * p2(12) + (used ? (imm & (p2(12) - 1)) : 0);
    e.instr = 32'(f);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: pops compared first, then this cycle's accept is recorded.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall) chk("hold_instr", out_instr, prev_instr);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_without_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_err", out_err, e.code != 2'd0);
          chk("out_err_code", out_err_code, e.code);
        end
      end
      if (in_valid && in_ready) begin
        e = model(int'(in_group), int'(in_op_type), int'(in_ra), int'(in_rb), int'(in_rc),
                  int'(in_oper), longint'(in_imm));
        exp_q.push_back(e);
        if (e.code == 2'd0) exp_cnt = exp_cnt + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic put(input int g, input int ot, input int ra, input int rb, input int rc,
                     input int oper, input longint imm);
    in_group = 3'(g); in_op_type = 1'(ot); in_ra = 4'(ra); in_rb = 4'(rb);
    in_rc = 4'(rc); in_oper = 4'(oper); in_imm = 64'(imm);
    in_valid = 1'b1;
  endtask

  task automatic wait_acc(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk({tag, "_accept_timeout"}, done, 1);
  endtask

  task automatic send(input int g, input int ot, input int ra, input int rb, input int rc,
                      input int oper, input longint imm);
    put(g, ot, ra, rb, rc, oper, imm);
    wait_acc("send");
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (exp_q.size() != 0); k++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    prev_stall = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic longint rand_imm();
    longint edges [8] = '{2047, -2048, 2048, -2049, 524287, -524288, 524288, -524289};
    case ($urandom_range(0, 4))
      0: return longint'($urandom_range(0, 4095)) - 2048;
      1: return longint'($urandom_range(0, 1048575)) - 524288;
      2: return edges[$urandom_range(0, 7)];
      3: return longint'({$urandom(), $urandom()});
      default: return 0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t   e;
    int     c0;
    int     g;
    bit     stop_rdy;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_code", out_err_code, 0);
    chk("rst_enc_count", enc_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Known encodings
    send(0, 1, 1, 2, 3, 0, 5);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_instr", out_instr, 32'h1123_0000);
    chk("t1_err", out_err, 0);
    chk("t1_enc_count", enc_count, 1);
    send(1, 0, 5, 0, 0, 0, -4);
    chk("t2_instr", out_instr, 32'h250F_FFFC);
    chk("t2_err", out_err, 0);
    send(2, 0, 0, 0, 0, 0, 2048);
    chk("t3_imm_err", out_err, 1);
    chk("t3_imm_code", out_err_code, 3);
    send(0, 0, 0, 0, 0, 13, -2048);
    chk("t3_neg_err", out_err, 0);
    chk("t3_neg_instr", out_instr, 32'h0000_D800);
    send(3, 0, 0, 0, 0, 9, 0);
    chk("t3_oper_code", out_err_code, 2);
    send(5, 0, 0, 0, 0, 0, 0);
    chk("t3_group_code", out_err_code, 1);
    chk("t3_enc_count", enc_count, 3);
    drain();

    // Backpressure: third word held until a slot frees
    out_ready = 1'b0;
    send(2, 0, 1, 1, 1, 1, 10);
    send(3, 0, 2, 2, 2, 2, -10);
    put(0, 0, 3, 3, 3, 12, 100);
    repeat (2) begin
      @(negedge clk);
      chk("t4_full_in_ready", in_ready, 0);
    end
    e = model(2, 0, 1, 1, 1, 1, 10);
    chk("t4_head_held", out_instr, e.instr);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_acc("t4_third");
    drain();
    chk("t4_out_valid_after_drain", out_valid, 0);

    // Streaming 100 legal words
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      g = $urandom_range(0, 3);
      send(g, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15),
           (g == 0) ? $urandom_range(0, 13) : (g == 1) ? $urandom_range(0, 2) : $urandom_range(0, 8),
           (g == 1) ? longint'($urandom_range(0, 1048575)) - 524288
                    : longint'($urandom_range(0, 4095)) - 2048);
    end
    chk("t5_cycles_per_100", cyc - c0, 100);
    drain();
    chk("t5_enc_count", enc_count, 100);

    // Reset with words queued
    out_ready = 1'b0;
    send(0, 0, 1, 2, 3, 4, 0);
    send(2, 0, 4, 5, 6, 7, 33);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid_in_reset", out_valid, 0);
    chk("t6_enc_count_in_reset", enc_count, 0);
    prev_stall = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1, 0, 9, 0, 0, 1, 777);
    e = model(1, 0, 9, 0, 0, 1, 777);
    chk("t6_first_after_reset", out_instr, e.instr);
    drain();

    // Random mix with random consumer stalls
    stop_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          g = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
          send(g, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), rand_imm());
        end
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("t7_enc_count", enc_count, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
